// File: rtl/filter_chain_sequencer.sv
// Runs up to three filter stages in order over one shared frame memory port,
// ping-ponging frame buffers A and B between consecutive enabled stages.
module filter_chain_sequencer #(
    parameter int FRAME_WORDS    = 76800,
    parameter int TIMEOUT_CYCLES = 1 << 22
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   pass_mask,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic         result_sel,
    output logic [1:0]   active_stage,
    output logic [2:0]   stage_start,
    input  logic [2:0]   stage_done,
    input  logic [56:0]  stage_read_addr,
    input  logic [56:0]  stage_write_addr,
    input  logic [107:0] stage_write_data,
    input  logic [2:0]   stage_we,
    output logic [18:0]  mem_read_addr,
    output logic [18:0]  mem_write_addr,
    output logic [35:0]  mem_write_data,
    output logic         mem_we
);

    localparam int AW    = 19;
    localparam int DW    = 36;
    localparam int NS    = 3;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [AW-1:0]    FRAME_SIZE = AW'(FRAME_WORDS);
    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       NO_STAGE   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t           state;
    logic [2:0]       mask_q;
    logic             src_sel;
    logic             done_prev;
    logic [CNT_W-1:0] timer;

    logic [1:0] first_stage;
    logic [1:0] later_stage;
    logic       cur_done;
    logic [3:0] done_ext;

    // Lowest enabled stage with index >= lo; NO_STAGE when none remains.
    function automatic logic [1:0] pick_stage(input logic [2:0] mask, input int lo);
        logic [1:0] idx;
        idx = NO_STAGE;
        for (int i = NS - 1; i >= 0; i--) begin
            if (mask[i] && i >= lo) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        first_stage = pick_stage(pass_mask, 0);
        later_stage = pick_stage(mask_q, int'(active_stage) + 1);
        done_ext    = {1'b0, stage_done};
        cur_done    = done_ext[active_stage];
    end

    // NOTE: sequential state uses non-blocking assignments only; the pulse
    // defaults at the top are overridden by later assignments in the case.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            mask_q       <= '0;
            src_sel      <= 1'b0;
            done_prev    <= 1'b0;
            timer        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            result_sel   <= 1'b0;
            active_stage <= NO_STAGE;
            stage_start  <= '0;
        end else begin
            stage_start <= '0;
            done        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mask_q     <= pass_mask;
                        error      <= 1'b0;
                        src_sel    <= 1'b0;
                        busy       <= 1'b1;
                        result_sel <= 1'b0;
                        if (first_stage == NO_STAGE) begin
                            state <= S_FINISH;
                        end else begin
                            state        <= S_LAUNCH;
                            active_stage <= first_stage;
                            stage_start  <= 3'b001 << first_stage;
                        end
                    end
                end
                S_LAUNCH: begin
                    // A done level already present at launch must not count as completion.
                    state     <= S_WAIT;
                    timer     <= '0;
                    done_prev <= cur_done;
                end
                S_WAIT: begin
                    done_prev <= cur_done;
                    if (cur_done && !done_prev) begin
                        state <= S_NEXT;
                    end else if (timer == TIMER_LAST) begin
                        error <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_NEXT: begin
                    result_sel <= ~src_sel;
                    src_sel    <= ~src_sel;
                    if (later_stage == NO_STAGE) begin
                        state <= S_FINISH;
                    end else begin
                        state        <= S_LAUNCH;
                        active_stage <= later_stage;
                        stage_start  <= 3'b001 << later_stage;
                    end
                end
                S_FINISH: begin
                    done         <= 1'b1;
                    busy         <= 1'b0;
                    active_stage <= NO_STAGE;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [AW-1:0] rd_local;
    logic [AW-1:0] wr_local;
    logic [DW-1:0] wd_local;
    logic          we_local;
    logic [AW-1:0] src_base;
    logic [AW-1:0] dst_base;

    // Purely combinational so the stage sees the same address timing as a direct connection.
    always_comb begin
        rd_local       = '0;
        wr_local       = '0;
        wd_local       = '0;
        we_local       = 1'b0;
        src_base       = src_sel ? FRAME_SIZE : '0;
        dst_base       = src_sel ? '0 : FRAME_SIZE;
        mem_read_addr  = '0;
        mem_write_addr = '0;
        mem_write_data = '0;
        mem_we         = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (active_stage == 2'(i)) begin
                rd_local = stage_read_addr[i*AW +: AW];
                wr_local = stage_write_addr[i*AW +: AW];
                wd_local = stage_write_data[i*DW +: DW];
                we_local = stage_we[i];
            end
        end
        if (state == S_LAUNCH || state == S_WAIT) begin
            mem_read_addr  = rd_local + src_base;
            mem_write_addr = wr_local + dst_base;
            mem_write_data = wd_local;
            mem_we         = we_local && (wr_local < FRAME_SIZE);
        end
    end

endmodule

// File: tb/tb_filter_chain_sequencer.sv
// Directed bench for filter_chain_sequencer: full chain, single stage address
// table, zero mask, timeout, held done level and mid-run reset.
module tb_filter_chain_sequencer;

    localparam int FW = 76800;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   pass_mask = '0;
    logic         busy, done, error, result_sel, mem_we;
    logic [1:0]   active_stage;
    logic [2:0]   stage_start;
    logic [2:0]   stage_done = '0;
    logic [56:0]  stage_read_addr = '0;
    logic [56:0]  stage_write_addr = '0;
    logic [107:0] stage_write_data = '0;
    logic [2:0]   stage_we = '0;
    logic [18:0]  mem_read_addr, mem_write_addr;
    logic [35:0]  mem_write_data;

    int n_vec = 0;
    int n_bad = 0;

    filter_chain_sequencer #(
        .FRAME_WORDS   (FW),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .pass_mask       (pass_mask),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .result_sel      (result_sel),
        .active_stage    (active_stage),
        .stage_start     (stage_start),
        .stage_done      (stage_done),
        .stage_read_addr (stage_read_addr),
        .stage_write_addr(stage_write_addr),
        .stage_write_data(stage_write_data),
        .stage_we        (stage_we),
        .mem_read_addr   (mem_read_addr),
        .mem_write_addr  (mem_write_addr),
        .mem_write_data  (mem_write_data),
        .mem_we          (mem_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [18:0] rd;
        logic [18:0] wr;
        logic [35:0] wd;
        logic        we;
        logic [18:0] exp_rd;
        logic [18:0] exp_wr;
        logic        exp_we;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_slot(input int k, input logic [18:0] rd, input logic [18:0] wr,
                            input logic [35:0] wd, input logic we);
        stage_read_addr[k*19 +: 19]  = rd;
        stage_write_addr[k*19 +: 19] = wr;
        stage_write_data[k*36 +: 36] = wd;
        stage_we[k]                  = we;
    endtask

    // Returns at the negedge inside the cycle that follows the accepting edge.
    task automatic run_start(input logic [2:0] m);
        @(negedge clk);
        pass_mask = m;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (done) return;
        end
        cycles = budget + 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt[3];
        int dur[3];
        int order_idx;
        int done_seen;
        int done_cycle;
        int lat;

        vecs[0] = '{1'b0, 19'd5,     19'd7,      36'h123456789, 1'b1, 19'd5,     19'd76807,  1'b1};
        vecs[1] = '{1'b0, 19'd0,     19'd0,      36'hFFFFFFFFF, 1'b1, 19'd0,     19'd76800,  1'b1};
        vecs[2] = '{1'b1, 19'd76799, 19'd76799,  36'h000000001, 1'b1, 19'd76799, 19'd153599, 1'b1};
        vecs[3] = '{1'b0, 19'd76800, 19'd76800,  36'h0000ABCDE, 1'b1, 19'd76800, 19'd153600, 1'b0};
        vecs[4] = '{1'b0, 19'd1000,  19'd131071, 36'h800000000, 1'b1, 19'd1000,  19'd207871, 1'b0};
        vecs[5] = '{1'b0, 19'd42,    19'd9,      36'h55555AAAA, 1'b0, 19'd42,    19'd76809,  1'b0};

        // Reset state, with an active write request already on stage 0's port.
        set_slot(0, 19'd9, 19'd9, 36'h9, 1'b1);
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_result_sel", result_sel, 0);
        check("rst_active_stage", active_stage, 3);
        check("rst_stage_start", stage_start, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_read_addr", mem_read_addr, 0);
        check("rst_mem_write_addr", mem_write_addr, 0);
        check("rst_mem_write_data", mem_write_data, 0);
        reset = 1'b1;

        // Full chain, stages finish 20/30/40 cycles after their start pulse.
        for (int k = 0; k < 3; k++) begin
            set_slot(k, 19'(100 + k), 19'(200 + k), 36'(36'h500 + k), 1'b1);
            cnt[k] = 0;
        end
        dur[0] = 20; dur[1] = 30; dur[2] = 40;
        order_idx = 0; done_seen = 0; done_cycle = -1;
        run_start(3'b111);
        for (int cyc = 0; cyc < 120; cyc++) begin
            stage_done = '0;
            for (int k = 0; k < 3; k++) begin
                if (stage_start[k]) begin
                    check("chain_launch_order", k, order_idx);
                    check("chain_active_stage", active_stage, k);
                    check("chain_rd_addr", mem_read_addr, 100 + k + ((k % 2 == 1) ? FW : 0));
                    check("chain_wr_addr", mem_write_addr, 200 + k + ((k % 2 == 1) ? 0 : FW));
                    check("chain_wr_data", mem_write_data, 36'h500 + k);
                    check("chain_mem_we", mem_we, 1);
                    cnt[k] = dur[k];
                    order_idx++;
                end else if (cnt[k] > 0) begin
                    cnt[k]--;
                    if (cnt[k] == 0) stage_done[k] = 1'b1;
                end
            end
            if (done) begin
                done_seen++;
                done_cycle = cyc;
                check("chain_result_sel", result_sel, 1);
                check("chain_error", error, 0);
                check("chain_busy_at_done", busy, 0);
                check("chain_active_idle", active_stage, 3);
            end
            @(negedge clk);
        end
        check("chain_launch_count", order_idx, 3);
        check("chain_done_count", done_seen, 1);
        check("chain_done_cycle", done_cycle, 97);

        // Zero mask: done two cycles after start, buffer A, no stage launched.
        run_start(3'b000);
        check("zero_busy", busy, 1);
        check("zero_done_early", done, 0);
        check("zero_stage_start", stage_start, 0);
        check("zero_mem_we", mem_we, 0);
        @(negedge clk);
        check("zero_done", done, 1);
        check("zero_busy_end", busy, 0);
        check("zero_result_sel", result_sel, 0);
        check("zero_stage_start_end", stage_start, 0);
        @(negedge clk);
        check("zero_done_pulse", done, 0);

        // Stage 1 only: address table, src=A dst=B, other ports and dones ignored.
        set_slot(0, 19'd11, 19'd22, 36'h111, 1'b1);
        set_slot(1, 19'd0, 19'd0, 36'h0, 1'b0);
        set_slot(2, 19'd33, 19'd44, 36'h333, 1'b1);
        run_start(3'b010);
        check("s1_stage_start", stage_start, 3'b010);
        check("s1_active_stage", active_stage, 1);
        for (int i = 0; i < 6; i++) begin
            start     = vecs[i].start;
            pass_mask = 3'b111;
            set_slot(1, vecs[i].rd, vecs[i].wr, vecs[i].wd, vecs[i].we);
            stage_done = 3'b101;
            #1;
            check("tbl_rd_addr", mem_read_addr, vecs[i].exp_rd);
            check("tbl_wr_addr", mem_write_addr, vecs[i].exp_wr);
            check("tbl_wr_data", mem_write_data, vecs[i].wd);
            check("tbl_mem_we", mem_we, vecs[i].exp_we);
            check("tbl_busy", busy, 1);
            @(negedge clk);
        end
        start = 1'b0;
        check("s1_no_early_done", done, 0);
        check("s1_still_stage1", active_stage, 1);
        check("s1_no_restart", stage_start, 0);
        stage_done = 3'b010;
        @(negedge clk);
        stage_done = 3'b000;
        check("s1_next_no_done", done, 0);
        @(negedge clk);
        check("s1_result_sel", result_sel, 1);
        check("s1_finish_no_done", done, 0);
        @(negedge clk);
        check("s1_done", done, 1);
        check("s1_busy_end", busy, 0);

        // Timeout: stage 0 never completes; 64 cycles in WAIT.
        run_start(3'b001);
        for (int i = 1; i <= 64; i++) @(negedge clk);
        check("to_error_before", error, 0);
        check("to_busy_before", busy, 1);
        @(negedge clk);
        check("to_error", error, 1);
        check("to_done_not_yet", done, 0);
        @(negedge clk);
        check("to_done", done, 1);
        check("to_error_held", error, 1);
        check("to_result_sel", result_sel, 0);
        run_start(3'b000);
        check("to_error_cleared", error, 0);
        @(negedge clk);
        check("to_clear_run_done", done, 1);

        // Done level held from before start, and an out-of-frame write.
        stage_done = 3'b001;
        set_slot(0, 19'd3, 19'd76800, 36'h777, 1'b1);
        run_start(3'b001);
        check("held_mem_we", mem_we, 0);
        check("held_wr_addr", mem_write_addr, 153600);
        check("held_rd_addr", mem_read_addr, 3);
        repeat (10) @(negedge clk);
        check("held_busy", busy, 1);
        check("held_no_done", done, 0);
        check("held_active", active_stage, 0);
        check("held_mem_we_wait", mem_we, 0);
        stage_done = 3'b000;
        @(negedge clk);
        stage_done = 3'b001;
        wait_done(10, lat);
        check("held_done_latency", lat, 3);
        check("held_result_sel", result_sel, 1);
        check("held_error", error, 0);

        // Reset in the middle of WAIT with a write in flight.
        stage_done = 3'b000;
        set_slot(0, 19'd3, 19'd10, 36'h888, 1'b1);
        run_start(3'b001);
        repeat (5) @(negedge clk);
        check("mid_mem_we_before", mem_we, 1);
        check("mid_busy_before", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_mem_we", mem_we, 0);
        check("mid_busy", busy, 0);
        check("mid_stage_start", stage_start, 0);
        check("mid_active", active_stage, 3);
        check("mid_wr_addr", mem_write_addr, 0);
        @(negedge clk);
        reset = 1'b1;
        set_slot(2, 19'd50, 19'd60, 36'h999, 1'b1);
        run_start(3'b100);
        check("post_stage_start", stage_start, 3'b100);
        check("post_rd_addr", mem_read_addr, 50);
        check("post_wr_addr", mem_write_addr, 60 + FW);
        @(negedge clk);
        stage_done = 3'b100;
        wait_done(10, lat);
        check("post_done_latency", lat, 3);
        check("post_result_sel", result_sel, 1);
        check("post_error", error, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
